aes_ctr_stream: RTL and testbench
=================================

# aes_ctr_stream

Counter-mode streaming front/back end for the pipelined AES-256 core (`top`, ports CLK/STATE/KEY/OUT, fixed latency 56, one block per cycle, no stall). It accepts plaintext blocks on a ready/valid stream and issues incrementing counter blocks plus the key to the core. It tracks in-flight blocks with a valid delay line, XORs the returning keystream with the buffered plaintext, and presents ciphertext on a ready/valid output stream. Credit-based flow control absorbs downstream backpressure, which is necessary because the core pipeline cannot be stalled.

## Interface
- LATENCY, 56: core cycles from STATE sampled to OUT valid.
- DEPTH, 64: power of two; capacity of plaintext FIFO and result FIFO; credit pool size.
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- CFG_LOAD  in  1  one-cycle pulse: load CFG_KEY/CFG_IV.
- CFG_KEY  in  256  AES-256 key.
- CFG_IV  in  128  initial counter block.
- CFG_READY  out  1  block idle; CFG_LOAD accepted.
- S_VALID / S_READY  in / out  1  plaintext handshake.
- S_DATA  in  128  plaintext block.
- M_VALID / M_READY  out / in  1  ciphertext handshake.
- M_DATA  out  128  ciphertext block.
- CORE_STATE  out  128  to core STATE.
- CORE_KEY  out  256  to core KEY.
- CORE_OUT  in  128  from core OUT.

## Operation
- Registers: key_q, ctr_q (128), configured, issue tag delay line (LATENCY bits), plaintext FIFO, result FIFO.
- Idle means: no tag set in the delay line, and both FIFOs empty. CFG_READY = idle.
- CFG_LOAD && CFG_READY: key_q ← CFG_KEY, ctr_q ← CFG_IV, configured ← 1. When not idle, CFG_LOAD is ignored with no state change.
- occ = plaintext FIFO count + result FIFO count. credit = DEPTH − occ.
- S_READY = configured && credit != 0 && !CFG_LOAD. CFG_LOAD has priority over issue in the same cycle.
- Issue, on S_VALID && S_READY:
  - push S_DATA into the plaintext FIFO.
  - CORE_STATE reg ← ctr_q; CORE_KEY reg ← key_q.
  - ctr_q ← ctr_q + 1, mod 2^128 (full wrap, all-ones → zero).
  - tag input ← 1.
- No issue: CORE_STATE/CORE_KEY hold their value; tag input ← 0.
- Capture: when the delay-line output tag is 1, push CORE_OUT ^ (plaintext FIFO head) into the result FIFO and pop the plaintext FIFO in the same cycle.
- M_VALID = result FIFO non-empty; M_DATA = head. Pop on M_VALID && M_READY.
- Overflow cannot occur: the credit rule guarantees a result FIFO slot exists for every in-flight block. A capture and a pop in the same cycle are both performed.
- Output ordering equals input ordering. There is no drop and no duplication.

## Timing
- Reset values: S_READY 0, M_VALID 0, M_DATA 0, CORE_STATE 0, CORE_KEY 0, CFG_READY 1. configured 0, ctr_q 0, key_q 0, all tags 0, FIFOs empty.
- Handshake in cycle c: CORE_STATE is valid in c+1 and sampled by the core at the end of c+1. CORE_OUT is valid in c+1+LATENCY and captured at its end. M_VALID rises in c+2+LATENCY. Input-to-output latency is LATENCY+2 cycles.
- Throughput is 1 block/cycle sustained with M_READY=1. This requires DEPTH ≥ LATENCY+3; the default satisfies it.
- Credit update is registered. A pop and an issue in the same cycle leave occ unchanged.
- RST mid-operation: all in-flight and buffered blocks are discarded; configured is cleared, so CFG_LOAD is required again.
- Configuration persists across any number of blocks. The counter continues from its last value, with no reload, until the next accepted CFG_LOAD.

## Test plan
- NIST SP800-38A F.5.5:
  - stimulus: CFG_KEY 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, CFG_IV f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, S_DATA 6bc1bee22e409f96e93d7e117393172a.
  - required: M_DATA 601ec313775789a5b7a7f504bbf3d228, with M_VALID exactly LATENCY+2 cycles after the handshake.
- Streaming: 500 back-to-back blocks with M_READY=1 → S_READY never drops after the first issue; outputs are contiguous and match the software CTR model in order.
- Backpressure: M_READY=0, S_VALID=1 → exactly DEPTH (64) handshakes, then S_READY=0. Raising M_READY releases all 64 correct blocks with none lost.
- Counter wrap: CFG_IV all-ones, 2 blocks → CORE_STATE sequence ffff…ff then 0000…00.
- CFG_LOAD while blocks are in flight → ignored: CFG_READY=0 and results still use the old key. A CFG_LOAD after drain takes effect.
- RST asserted mid-stream with 20 blocks in flight → all outputs at reset values immediately. After release and reconfiguration, the first output is correct and no stale block appears.

Source files
------------

// File: rtl/aes_ctr_stream.sv
// aes_ctr_stream
// Counter-mode streaming wrapper around a pipelined, non-stallable AES-256 core.
// Plaintext blocks are accepted on a ready/valid stream, each one issues the
// current counter block and key to the core, and the returning keystream is
// XORed with the buffered plaintext and presented on a ready/valid output.
// Downstream backpressure is absorbed by a credit pool. Every block in flight
// or buffered holds one credit, so the result FIFO can always take a
// returning block.
//
// Ports
//   CLK, RST              clock (rising edge); asynchronous active-high reset
//   CFG_LOAD/KEY/IV       load key and initial counter (accepted only when idle)
//   CFG_READY             block is idle and configuration may be loaded
//   S_VALID/READY/DATA    plaintext input stream
//   M_VALID/READY/DATA    ciphertext output stream
//   CORE_STATE/CORE_KEY   counter block and key driven to the core
//   CORE_OUT              keystream returned by the core, LATENCY cycles later
module aes_ctr_stream #(
    parameter int LATENCY = 56,
    parameter int DEPTH   = 64
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         CFG_LOAD,
    input  logic [255:0] CFG_KEY,
    input  logic [127:0] CFG_IV,
    output logic         CFG_READY,
    input  logic         S_VALID,
    output logic         S_READY,
    input  logic [127:0] S_DATA,
    output logic         M_VALID,
    input  logic         M_READY,
    output logic [127:0] M_DATA,
    output logic [127:0] CORE_STATE,
    output logic [255:0] CORE_KEY,
    input  logic [127:0] CORE_OUT
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [255:0] key_q;
    logic [127:0] ctr_q;
    logic         configured_q;
    logic [127:0] core_state_q;
    logic [255:0] core_key_q;

    // Bit 0 lines up with CORE_STATE; bit LATENCY lines up with CORE_OUT.
    logic [LATENCY:0] tag_q;

    logic [127:0] pt_mem  [DEPTH];
    logic [AW-1:0] pt_wr_q, pt_rd_q;
    logic [CW-1:0] pt_cnt_q;

    logic [127:0] res_mem [DEPTH];
    logic [AW-1:0] res_wr_q, res_rd_q;
    logic [CW-1:0] res_cnt_q;

    logic [CW-1:0] occ;
    logic          idle;
    logic          cfg_accept;
    logic          issue;
    logic          capture;
    logic          pop;

    always_comb begin
        occ        = pt_cnt_q + res_cnt_q;
        idle       = (tag_q == '0) && (pt_cnt_q == '0) && (res_cnt_q == '0);
        cfg_accept = CFG_LOAD && idle;
        // A configuration request blocks issue in the same cycle, even if it
        // is about to be ignored.
        S_READY    = configured_q && (occ != CW'(DEPTH)) && !CFG_LOAD;
        issue      = S_VALID && S_READY;
        capture    = tag_q[LATENCY];
        M_VALID    = (res_cnt_q != '0);
        pop        = M_VALID && M_READY;
        // Forced to zero while empty so the output is clean right after reset.
        M_DATA     = M_VALID ? res_mem[res_rd_q] : '0;
        CFG_READY  = idle;
        CORE_STATE = core_state_q;
        CORE_KEY   = core_key_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            key_q        <= '0;
            ctr_q        <= '0;
            configured_q <= 1'b0;
            core_state_q <= '0;
            core_key_q   <= '0;
            tag_q        <= '0;
            pt_wr_q      <= '0;
            pt_rd_q      <= '0;
            pt_cnt_q     <= '0;
            res_wr_q     <= '0;
            res_rd_q     <= '0;
            res_cnt_q    <= '0;
        end else begin
            tag_q <= {tag_q[LATENCY-1:0], issue};
            if (cfg_accept) begin
                key_q        <= CFG_KEY;
                ctr_q        <= CFG_IV;
                configured_q <= 1'b1;
            end else if (issue) begin
                ctr_q <= ctr_q + 128'd1;
            end
            if (issue) begin
                core_state_q <= ctr_q;
                core_key_q   <= key_q;
                pt_wr_q      <= pt_wr_q + AW'(1);
            end
            if (capture) begin
                pt_rd_q  <= pt_rd_q + AW'(1);
                res_wr_q <= res_wr_q + AW'(1);
            end
            if (pop) begin
                res_rd_q <= res_rd_q + AW'(1);
            end
            pt_cnt_q  <= pt_cnt_q + CW'(issue) - CW'(capture);
            res_cnt_q <= res_cnt_q + CW'(capture) - CW'(pop);
        end
    end

    // Storage arrays carry no reset; the pointers and counts define validity.
    always_ff @(posedge CLK) begin
        if (issue) begin
            pt_mem[pt_wr_q] <= S_DATA;
        end
        if (capture) begin
            res_mem[res_wr_q] <= CORE_OUT ^ pt_mem[pt_rd_q];
        end
    end

endmodule

// File: tb/tb_aes_ctr_stream.sv
module tb_aes_ctr_stream;

    localparam int LATENCY = 56;
    localparam int DEPTH   = 64;

    logic         CLK = 1'b0;
    logic         RST;
    logic         CFG_LOAD;
    logic [255:0] CFG_KEY;
    logic [127:0] CFG_IV;
    logic         CFG_READY;
    logic         S_VALID;
    logic         S_READY;
    logic [127:0] S_DATA;
    logic         M_VALID;
    logic         M_READY;
    logic [127:0] M_DATA;
    logic [127:0] CORE_STATE;
    logic [255:0] CORE_KEY;
    logic [127:0] CORE_OUT;

    aes_ctr_stream #(.LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST),
        .CFG_LOAD(CFG_LOAD), .CFG_KEY(CFG_KEY), .CFG_IV(CFG_IV), .CFG_READY(CFG_READY),
        .S_VALID(S_VALID), .S_READY(S_READY), .S_DATA(S_DATA),
        .M_VALID(M_VALID), .M_READY(M_READY), .M_DATA(M_DATA),
        .CORE_STATE(CORE_STATE), .CORE_KEY(CORE_KEY), .CORE_OUT(CORE_OUT)
    );

    always #5 CLK = ~CLK;

    // ---------------- behavioural AES-256 ----------------
    logic [7:0] sbox [256];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    function automatic logic [127:0] aes256(input logic [127:0] blk, input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  s [16];
        logic [7:0]  r [16];
        logic [7:0]  rc = 8'h01;
        logic [7:0]  a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (i % 8 == 4) begin
                t = subw(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int i = 0; i < 16; i++) s[i] = blk[127-8*i -: 8];
        for (int rnd = 0; rnd <= 14; rnd++) begin
            if (rnd > 0) begin
                for (int i = 0; i < 16; i++) s[i] = sbox[s[i]];
                for (int c = 0; c < 4; c++)
                    for (int q = 0; q < 4; q++) r[4*c+q] = s[4*((c+q)%4)+q];
                for (int i = 0; i < 16; i++) s[i] = r[i];
                if (rnd < 14) begin
                    for (int c = 0; c < 4; c++) begin
                        a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                        s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                        s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                        s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                        s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                    end
                end
            end
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++) s[4*c+q] = s[4*c+q] ^ w[4*rnd+c][31-8*q -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- core model: fixed-latency pipeline, no reset ----------------
    logic [127:0] core_pipe [LATENCY];
    always @(posedge CLK) begin
        core_pipe[0] <= aes256(CORE_STATE, CORE_KEY);
        for (int k = LATENCY - 1; k > 0; k--) core_pipe[k] <= core_pipe[k-1];
    end
    assign CORE_OUT = core_pipe[LATENCY-1];

    // ---------------- reference model state ----------------
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int issued = 0;
    int out_cnt = 0;
    int drops = 0;
    int last_issue_cyc = 0;
    int last_out_cyc = 0;
    logic [127:0] last_out_data = '0;
    logic monitor_drop = 1'b0;

    logic         model_cfg = 1'b0;
    logic [255:0] model_key = '0;
    logic [127:0] model_ctr = '0;
    logic [127:0] exp_data [$];
    int           exp_cyc  [$];
    logic         prev_issue = 1'b0;
    logic [127:0] prev_ctr = '0;
    logic [255:0] prev_key = '0;
    logic [127:0] cs_log [$];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One clock cycle: observe at the falling edge, update the model, then
    // advance past the rising edge.
    task automatic tick();
        logic hs;
        logic pop;
        logic exp_mv;
        hs = 1'b0;
        @(negedge CLK);
        if (!RST) begin
            exp_mv = (exp_data.size() > 0) && (cyc >= exp_cyc[0] + LATENCY + 2);
            chk("cfg_ready", 256'(CFG_READY), 256'(exp_data.size() == 0));
            chk("s_ready", 256'(S_READY),
                256'(model_cfg && (exp_data.size() < DEPTH) && !CFG_LOAD));
            chk("m_valid", 256'(M_VALID), 256'(exp_mv));
            if (prev_issue) begin
                chk("core_state", 256'(CORE_STATE), 256'(prev_ctr));
                chk("core_key", CORE_KEY, prev_key);
                cs_log.push_back(CORE_STATE);
            end
            if (monitor_drop && !S_READY) drops++;
            hs  = S_VALID && S_READY;
            pop = M_VALID && M_READY;
            if (pop && exp_data.size() > 0) begin
                chk("m_data", 256'(M_DATA), 256'(exp_data[0]));
                $display("[TB] out  cyc=%0d data=%h", cyc, M_DATA);
                void'(exp_data.pop_front());
                void'(exp_cyc.pop_front());
                last_out_data = M_DATA;
                last_out_cyc  = cyc;
                out_cnt++;
            end
            if (CFG_LOAD && exp_data.size() == 0 && !hs) begin
                model_cfg = 1'b1;
                model_key = CFG_KEY;
                model_ctr = CFG_IV;
            end
            prev_issue = hs;
            if (hs) begin
                prev_ctr = model_ctr;
                prev_key = model_key;
                exp_data.push_back(S_DATA ^ aes256(model_ctr, model_key));
                exp_cyc.push_back(cyc);
                $display("[TB] in   cyc=%0d ctr=%h data=%h", cyc, model_ctr, S_DATA);
                model_ctr = model_ctr + 128'd1;
                last_issue_cyc = cyc;
                issued++;
            end
        end
        @(posedge CLK);
        #1;
        cyc++;
        if (hs) S_DATA = rand128();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        #1;
        chk("rst_s_ready", 256'(S_READY), 256'(0));
        chk("rst_m_valid", 256'(M_VALID), 256'(0));
        chk("rst_m_data", 256'(M_DATA), 256'(0));
        chk("rst_core_state", 256'(CORE_STATE), 256'(0));
        chk("rst_core_key", CORE_KEY, 256'(0));
        chk("rst_cfg_ready", 256'(CFG_READY), 256'(1));
        exp_data.delete();
        exp_cyc.delete();
        model_cfg  = 1'b0;
        model_key  = '0;
        model_ctr  = '0;
        prev_issue = 1'b0;
        repeat (3) tick();
        RST = 1'b0;
    endtask

    task automatic configure(input logic [255:0] k, input logic [127:0] iv);
        CFG_KEY  = k;
        CFG_IV   = iv;
        CFG_LOAD = 1'b1;
        tick();
        CFG_LOAD = 1'b0;
    endtask

    task automatic run_until_issued(input int target, input int budget);
        int b = 0;
        while (issued < target && b < budget) begin
            tick();
            b++;
        end
        chk("issue_budget", 256'(issued), 256'(target));
    endtask

    task automatic drain(input int budget);
        int b = 0;
        while (exp_data.size() > 0 && b < budget) begin
            tick();
            b++;
        end
        chk("drain_budget", 256'(exp_data.size()), 256'(0));
    endtask

    initial begin
        int start;
        int o0;
        int b;
        int cs0;
        logic [255:0] ka, kb;
        logic [127:0] inv;

        // S-box from GF(2^8) inverse plus affine transform.
        for (int x = 0; x < 256; x++) begin
            inv = '0;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv[7:0] = 8'(y);
            sbox[x] = inv[7:0] ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end

        CFG_LOAD = 1'b0; CFG_KEY = '0; CFG_IV = '0;
        S_VALID = 1'b0; S_DATA = '0; M_READY = 1'b0;
        do_reset();

        // Known-answer vector with exact latency.
        configure(256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                  128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff);
        S_DATA  = 128'h6bc1bee22e409f96e93d7e117393172a;
        S_VALID = 1'b1;
        M_READY = 1'b1;
        run_until_issued(issued + 1, 10);
        S_VALID = 1'b0;
        o0 = out_cnt;
        b = 0;
        while (out_cnt == o0 && b < 200) begin
            tick();
            b++;
        end
        chk("kat_data", 256'(last_out_data), 256'(128'h601ec313775789a5b7a7f504bbf3d228));
        chk("kat_latency", 256'(last_out_cyc - last_issue_cyc), 256'(LATENCY + 2));

        // 500 back-to-back random blocks.
        start = issued;
        o0 = out_cnt;
        drops = 0;
        S_DATA = rand128();
        S_VALID = 1'b1;
        b = 0;
        while (issued < start + 500 && b < 700) begin
            tick();
            if (issued > start) monitor_drop = 1'b1;
            b++;
        end
        monitor_drop = 1'b0;
        S_VALID = 1'b0;
        chk("stream_issued", 256'(issued - start), 256'(500));
        chk("stream_ready_drops", 256'(drops), 256'(0));
        drain(200);
        chk("stream_outputs", 256'(out_cnt - o0), 256'(500));

        // Backpressure: credit pool fills at exactly DEPTH.
        start = issued;
        o0 = out_cnt;
        M_READY = 1'b0;
        S_VALID = 1'b1;
        repeat (100) tick();
        chk("bp_accepted", 256'(issued - start), 256'(DEPTH));
        chk("bp_s_ready", 256'(S_READY), 256'(0));
        S_VALID = 1'b0;
        M_READY = 1'b1;
        drain(300);
        chk("bp_released", 256'(out_cnt - o0), 256'(DEPTH));

        // Counter wrap.
        configure({rand128(), rand128()}, {128{1'b1}});
        cs0 = cs_log.size();
        S_VALID = 1'b1;
        run_until_issued(issued + 2, 10);
        S_VALID = 1'b0;
        tick();
        chk("wrap_size", 256'(cs_log.size() - cs0), 256'(2));
        if (cs_log.size() >= cs0 + 2) begin
            chk("wrap_first", 256'(cs_log[cs0]), 256'({128{1'b1}}));
            chk("wrap_second", 256'(cs_log[cs0 + 1]), 256'(0));
        end
        drain(200);

        // Configuration while busy is ignored; after drain it takes effect.
        ka = {rand128(), rand128()};
        kb = {rand128(), rand128()};
        configure(ka, rand128());
        S_VALID = 1'b1;
        run_until_issued(issued + 5, 10);
        S_VALID = 1'b0;
        chk("cfg_busy_ready", 256'(CFG_READY), 256'(0));
        configure(kb, rand128());
        drain(200);
        configure(kb, rand128());
        S_VALID = 1'b1;
        run_until_issued(issued + 3, 10);
        S_VALID = 1'b0;
        chk("cfg_new_key", CORE_KEY, kb);
        drain(200);

        // Reset with 20 blocks in flight.
        configure({rand128(), rand128()}, rand128());
        M_READY = 1'b0;
        S_VALID = 1'b1;
        run_until_issued(issued + 20, 30);
        S_VALID = 1'b0;
        repeat (3) tick();
        do_reset();
        chk("post_rst_cfg_ready", 256'(CFG_READY), 256'(1));
        configure({rand128(), rand128()}, rand128());
        M_READY = 1'b1;
        o0 = out_cnt;
        S_VALID = 1'b1;
        run_until_issued(issued + 1, 10);
        S_VALID = 1'b0;
        drain(200);
        repeat (70) tick();
        chk("post_rst_outputs", 256'(out_cnt - o0), 256'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
